// File: rtl/mem_pkg.sv
// Shared widths, FSM encoding and request layout for the memory request front-end.
package mem_pkg;

  localparam int unsigned MEM_AW = 12;
  localparam int unsigned MEM_DW = 8;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Request FIFO entry, MSB first: {wr, add, din}
  typedef struct packed {
    logic              wr;
    logic [MEM_AW-1:0] add;
    logic [MEM_DW-1:0] din;
  } mem_req_t;

  function automatic int unsigned req_width(input int unsigned aw, input int unsigned dw);
    return 1 + aw + dw;
  endfunction

endpackage

// File: rtl/mem_req_ctrl_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; push when full / pop when empty are ignored.
module sync_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wp;
  logic [PW:0]  rp;
  logic         do_push;
  logic         do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + (PW+1)'(1);
      if (do_pop)  rp <= rp + (PW+1)'(1);
    end
  end

  // Storage needs no reset; pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wp[PW-1:0]] <= din;
  end

  assign count = wp - rp;
  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (wp == rp);
  assign dout  = mem[rp[PW-1:0]];

endmodule

// File: rtl/mem_req_ctrl.sv
// Request front-end for the 4K x 8 memory: buffers commands, issues one access per
// cycle, returns read data in order, and optionally zero-fills the array after reset.
module mem_req_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned AW         = MEM_AW,
  parameter int unsigned DW         = MEM_DW,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned INIT_CLEAR = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wr,
  input  logic [AW-1:0] req_add,
  input  logic [DW-1:0] req_din,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          busy,
  output logic          cen,
  output logic          rd,
  output logic          wr,
  output logic [AW-1:0] add,
  output logic [DW-1:0] din,
  input  logic [DW-1:0] dout
);

  localparam int unsigned RW = req_width(AW, DW);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned OW = PW + 1;
  localparam int unsigned CW = PW + 2;
  localparam state_t      RST_ST = (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;

  state_t              state, state_d;
  logic [AW:0]         clr_cnt, clr_cnt_d;
  logic                cen_d, rd_d, wr_d;
  logic [AW-1:0]       add_d;
  logic [DW-1:0]       din_d;
  logic [RD_LAT-1:0]   rd_pipe;
  logic [OW-1:0]       out_cnt;

  logic [RW-1:0]       req_head;
  logic                req_full, req_empty, req_push, req_pop;
  logic [OW-1:0]       req_cnt;
  logic                head_wr;
  logic [AW-1:0]       head_add;
  logic [DW-1:0]       head_din;

  logic [DW-1:0]       rsp_head;
  logic                rsp_full, rsp_empty, rsp_push, rsp_pop;
  logic [OW-1:0]       rsp_cnt;

  logic                credit_ok, issue, rd_issue;
  logic [CW-1:0]       req_cnt_nxt, rsp_cnt_nxt, out_cnt_nxt;
  logic                ready_d, busy_d;

  assign req_push = req_valid & req_ready & ~req_full;
  assign head_wr  = req_head[RW-1];
  assign head_add = req_head[AW+DW-1:DW];
  assign head_din = req_head[DW-1:0];

  sync_fifo #(.W(RW), .DEPTH(DEPTH)) u_req_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_push),
    .din   ({req_wr, req_add, req_din}),
    .pop   (req_pop),
    .dout  (req_head),
    .full  (req_full),
    .empty (req_empty),
    .count (req_cnt)
  );

  assign rsp_push = rd_pipe[RD_LAT-1];
  assign rsp_pop  = rsp_valid & rsp_ready;

  sync_fifo #(.W(DW), .DEPTH(DEPTH)) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_push),
    .din   (dout),
    .pop   (rsp_pop),
    .dout  (rsp_head),
    .full  (rsp_full),
    .empty (rsp_empty),
    .count (rsp_cnt)
  );

  assign rsp_valid = ~rsp_empty;
  assign rsp_data  = rsp_empty ? '0 : rsp_head;

  // A read may issue only if its data is guaranteed a slot in the response FIFO.
  assign credit_ok = ~rsp_full & ((CW'(out_cnt) + CW'(rsp_cnt)) < CW'(DEPTH));
  assign issue     = (state == ST_RUN) & ~req_empty & (head_wr | credit_ok);
  assign rd_issue  = issue & ~head_wr;

  always_comb begin
    state_d   = state;
    clr_cnt_d = clr_cnt;
    cen_d     = 1'b0;
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    add_d     = add;
    din_d     = din;
    req_pop   = 1'b0;
    case (state)
      ST_INIT: begin
        if (clr_cnt[AW]) begin
          state_d = ST_RUN;
        end else begin
          cen_d     = 1'b1;
          wr_d      = 1'b1;
          add_d     = clr_cnt[AW-1:0];
          din_d     = '0;
          clr_cnt_d = clr_cnt + (AW+1)'(1);
        end
      end
      ST_RUN: begin
        if (issue) begin
          cen_d   = 1'b1;
          rd_d    = ~head_wr;
          wr_d    = head_wr;
          add_d   = head_add;
          din_d   = head_wr ? head_din : '0;
          req_pop = 1'b1;
        end
      end
      default: state_d = RST_ST;
    endcase
  end

  // Next-cycle occupancies so req_ready and busy can be registered.
  always_comb begin
    req_cnt_nxt = CW'(req_cnt) + CW'(req_push) - CW'(req_pop);
    rsp_cnt_nxt = CW'(rsp_cnt) + CW'(rsp_push) - CW'(rsp_pop);
    out_cnt_nxt = CW'(out_cnt) + CW'(rd_issue) - CW'(rsp_push);
    ready_d     = (state_d == ST_RUN) & (req_cnt_nxt != CW'(DEPTH));
    busy_d      = (state_d == ST_INIT) | (req_cnt_nxt != '0) |
                  (out_cnt_nxt != '0) | (rsp_cnt_nxt != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RST_ST;
      clr_cnt   <= '0;
      cen       <= 1'b0;
      rd        <= 1'b0;
      wr        <= 1'b0;
      add       <= '0;
      din       <= '0;
      rd_pipe   <= '0;
      out_cnt   <= '0;
      req_ready <= 1'b0;
      busy      <= (INIT_CLEAR != 0);
    end else begin
      state     <= state_d;
      clr_cnt   <= clr_cnt_d;
      cen       <= cen_d;
      rd        <= rd_d;
      wr        <= wr_d;
      add       <= add_d;
      din       <= din_d;
      rd_pipe[0] <= rd;
      for (int i = 1; i < int'(RD_LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
      out_cnt   <= OW'(out_cnt_nxt);
      req_ready <= ready_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Self-checking bench for mem_req_ctrl with a behavioural 4K x 8 memory and a read-data scoreboard.
module tb_mem_req_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [11:0] req_add = '0;
  logic [7:0]  req_din = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [7:0]  rsp_data;
  logic        busy;
  logic        cen, rd, wr;
  logic [11:0] add;
  logic [7:0]  din;
  logic [7:0]  dout = '0;

  int total = 0;
  int bad = 0;
  int rd_issued = 0;
  int rsp_seen = 0;

  logic [7:0] exp_q[$];
  logic [7:0] shadow [4096];
  logic [7:0] mem_m [4096];
  logic       stall_prev = 1'b0;
  logic [7:0] stall_data = '0;

  always #5 clk = ~clk;

  mem_req_ctrl #(.AW(12), .DW(8), .DEPTH(4), .RD_LAT(1), .INIT_CLEAR(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_add   (req_add),
    .req_din   (req_din),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .cen       (cen),
    .rd        (rd),
    .wr        (wr),
    .add       (add),
    .din       (din),
    .dout      (dout)
  );

  // Synchronous memory: data appears the cycle after the read strobe is sampled.
  always @(posedge clk) begin
    if (cen && wr) mem_m[add] <= din;
    if (cen && rd) dout <= mem_m[add];
  end

  // Response scoreboard, stall-stability check and read-issue counter.
  always @(negedge clk) begin
    if (rst) begin
      if (stall_prev) begin
        total++;
        if (rsp_valid !== 1'b1 || rsp_data !== stall_data) begin
          bad++;
          $display("FAIL rsp_stable got valid=%b data=%h want valid=1 data=%h", rsp_valid, rsp_data, stall_data);
        end
      end
      stall_prev = (rsp_valid === 1'b1) && (rsp_ready === 1'b0);
      stall_data = rsp_data;
      if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        total++;
        rsp_seen++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rsp_unexpected got data=%h want no response", rsp_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (rsp_data !== e) begin
            bad++;
            $display("FAIL rsp_data got %h want %h", rsp_data, e);
          end
        end
      end
      if (cen === 1'b1 && rd === 1'b1) rd_issued++;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic send(input logic w, input logic [11:0] a, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_wr = w; req_add = a; req_din = d;
    while (req_ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL send_timeout got ready=%b want 1", req_ready);
      req_valid = 1'b0;
    end else begin
      if (w) shadow[a] = d;
      else exp_q.push_back(shadow[a]);
      @(posedge clk);
      #1 req_valid = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_drain got pending=%0d busy=%b want 0 0", name, exp_q.size(), busy);
    end
  endtask

  task automatic test_reset();
    #3 rst = 1'b0;
    #2;
    total++;
    if ({cen, rd, wr, add, din} !== 23'd0) begin
      bad++;
      $display("FAIL reset_pins got %b want 0", {cen, rd, wr, add, din});
    end
    total++;
    if ({rsp_valid, rsp_data, req_ready} !== 10'd0) begin
      bad++;
      $display("FAIL reset_rsp got valid=%b data=%h ready=%b want 0 00 0", rsp_valid, rsp_data, req_ready);
    end
  endtask

  task automatic test_init(input string name);
    int n_wr = 0;
    int errs = 0;
    int cyc = 0;
    for (int i = 0; i < 4096; i++) shadow[i] = 8'h00;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || req_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s_busy got busy=%b ready=%b want 1 0", name, busy, req_ready);
    end
    while (req_ready !== 1'b1 && cyc < 6000) begin
      if (cen === 1'b1 && wr === 1'b1) begin
        if (add !== 12'(n_wr) || din !== 8'h00 || rd !== 1'b0) errs++;
        n_wr++;
      end
      @(negedge clk);
      cyc++;
    end
    total++;
    if (n_wr != 4096 || errs != 0) begin
      bad++;
      $display("FAIL %s_sweep got writes=%0d bad_writes=%0d want 4096 0", name, n_wr, errs);
    end
    total++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || cen !== 1'b0) begin
      bad++;
      $display("FAIL %s_done got ready=%b busy=%b cen=%b want 1 0 0", name, req_ready, busy, cen);
    end
  endtask

  task automatic test_wr_rd();
    rsp_ready = 1'b1;
    send(1'b1, 12'h123, 8'hA5);
    send(1'b0, 12'h123, 8'h00);
    total++;
    if ({cen, rd, wr, add, din} !== {3'b101, 12'h123, 8'hA5}) begin
      bad++;
      $display("FAIL wr_pins got %b want %b", {cen, rd, wr, add, din}, {3'b101, 12'h123, 8'hA5});
    end
    @(posedge clk); #1;
    total++;
    if ({cen, rd, wr, add} !== {3'b110, 12'h123}) begin
      bad++;
      $display("FAIL rd_pins got %b want %b", {cen, rd, wr, add}, {3'b110, 12'h123});
    end
    @(posedge clk); #1;
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL rsp_early got valid=%b want 0", rsp_valid);
    end
    @(posedge clk); #1;
    total++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'hA5) begin
      bad++;
      $display("FAIL rsp_latency got valid=%b data=%h want 1 a5", rsp_valid, rsp_data);
    end
    drain("wr_rd");
  endtask

  task automatic test_backpressure();
    int seen0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(1'b1, 12'(i), 8'(8'h10 + i));
    drain("bp_fill");
    rsp_ready = 1'b0;
    rd_issued = 0;
    seen0 = rsp_seen;
    for (int i = 0; i < 8; i++) send(1'b0, 12'(i), 8'h00);
    repeat (6) @(negedge clk);
    total++;
    if (rd_issued != 4) begin
      bad++;
      $display("FAIL bp_issued got %0d want 4", rd_issued);
    end
    total++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL bp_stall got ready=%b valid=%b busy=%b want 0 1 1", req_ready, rsp_valid, busy);
    end
    rsp_ready = 1'b1;
    drain("bp");
    total++;
    if (rsp_seen - seen0 != 8) begin
      bad++;
      $display("FAIL bp_count got %0d want 8", rsp_seen - seen0);
    end
  endtask

  task automatic test_toggle();
    int seen0;
    bit sends_done = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(1'b1, 12'(12'h300 + i), 8'(8'h40 + i));
    drain("tog_fill");
    seen0 = rsp_seen;
    fork
      begin
        for (int i = 0; i < 16; i++) send(1'b0, 12'(12'h300 + i), 8'h00);
        sends_done = 1'b1;
      end
      begin
        int n = 0;
        while (!(sends_done && exp_q.size() == 0) && n < 400) begin
          @(posedge clk); #1;
          rsp_ready = ~rsp_ready;
          n++;
        end
        rsp_ready = 1'b1;
      end
    join
    drain("toggle");
    total++;
    if (rsp_seen - seen0 != 16) begin
      bad++;
      $display("FAIL toggle_count got %0d want 16", rsp_seen - seen0);
    end
  endtask

  task automatic test_reset_mid();
    int seen0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b0, 12'(12'h040 + i), 8'h00);
    rst = 1'b0;
    #2;
    total++;
    if ({cen, rd, wr, rsp_valid, req_ready} !== 5'b0) begin
      bad++;
      $display("FAIL midrst_pins got %b want 00000", {cen, rd, wr, rsp_valid, req_ready});
    end
    exp_q.delete();
    rsp_ready = 1'b1;
    seen0 = rsp_seen;
    test_init("reinit");
    repeat (4) @(negedge clk);
    total++;
    if (rsp_seen != seen0) begin
      bad++;
      $display("FAIL midrst_stale got %0d responses want 0", rsp_seen - seen0);
    end
  endtask

  task automatic test_same_addr();
    rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(1'b1, 12'hFFF, 8'(i));
      send(1'b0, 12'hFFF, 8'h00);
    end
    drain("same_addr");
  endtask

  initial begin
    test_reset();
    test_init("init");
    test_wr_rd();
    test_backpressure();
    test_toggle();
    test_reset_mid();
    test_same_addr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_req_ctrl.md
Name: mem_req_ctrl

Overview:
Request front-end that sits directly upstream of the 4K x 8 memory (mem_top) and drives its cen/rd/wr/add/din pins.
- Accepts read/write commands on a valid/ready stream and buffers them in a request FIFO.
- Issues at most one memory access per cycle.
- Captures memory dout after a fixed read latency and returns read data on a valid/ready response stream.
- Optionally sweeps the whole array to zero after reset before accepting traffic.

Parameters:
AW, 12, memory address width
DW, 8, memory data width
DEPTH, 4, request FIFO entries and response FIFO entries (power of 2, >=2)
RD_LAT, 1, cycles from rd/cen assertion to valid dout
INIT_CLEAR, 1, 1 = write zero to every address after reset before RUN

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  asynchronous active-low reset
req_valid  in  1  command valid
req_ready  out  1  command accepted when req_valid & req_ready
req_wr  in  1  1 = write, 0 = read
req_add  in  AW  command address
req_din  in  DW  write data (ignored for reads)
rsp_valid  out  1  read data valid
rsp_ready  in  1  consumer accepts read data
rsp_data  out  DW  read data, in request order
busy  out  1  high in INIT or when any request/read is pending
cen  out  1  memory chip enable, active high, registered
rd  out  1  memory read strobe, registered
wr  out  1  memory write strobe, registered
add  out  AW  memory address, registered
din  out  DW  memory write data, registered
dout  in  DW  memory read data

Behaviour:
- Reset (rst low, async):
  - cen/rd/wr = 0; add/din = 0; rsp_valid = 0; rsp_data = 0; req_ready = 0.
  - Both FIFOs empty; outstanding-read count = 0; state = INIT if INIT_CLEAR else RUN.
- FSM states: INIT, RUN.
  - INIT: a clear counter steps from 0 to 2^AW-1. Each cycle drives cen=1, wr=1, rd=0, add=counter, din=0.
  - INIT -> RUN the cycle after the write to address 2^AW-1 is issued (4096 cycles for AW=12).
  - req_ready = 0 throughout INIT.
- RUN:
  - req_ready = request FIFO not full. It depends only on registered state, with no combinational path from req_valid.
  - Issue condition: request FIFO non-empty AND (head is a write OR outstanding reads + response FIFO occupancy < DEPTH).
  - On issue: register cen=1, rd=~req_wr, wr=req_wr, add, din (din=0 for reads), and pop the head.
  - When nothing is issued: cen=rd=wr=0; add/din hold their last value.
  - Throughput: one access per cycle back to back. Enqueue-to-pin latency = 1 cycle when the FIFO is empty (push at edge N, pins valid after edge N+1).
- Read return:
  - Shift register of depth RD_LAT tags each issued read.
  - RD_LAT cycles after rd=1 is visible on the pins, sample dout into the response FIFO. The credit check guarantees space; overflow is impossible.
- Response output:
  - rsp_valid = response FIFO non-empty; rsp_data = head; pop on rsp_valid & rsp_ready.
  - rsp_data holds stable while rsp_valid=1 and rsp_ready=0.
- Ordering: strict program order. A read after a write to the same address returns the new data, because the memory sees the accesses in issue order.
- Simultaneous events: push and pop of the request FIFO in the same cycle when full is allowed only if the pop happens. req_ready is computed before the pop, so a full FIFO stalls one cycle.
- Pointers: log2(DEPTH)+1 bits, wrap naturally. The INIT counter is AW+1 bits, and its MSB ends INIT.
- Reset mid-operation: all pending requests, in-flight reads and buffered responses are discarded. INIT restarts if INIT_CLEAR=1.
- busy = (state==INIT) | request FIFO non-empty | outstanding reads != 0 | response FIFO non-empty.

Decomposition:
- Shared package mem_pkg: AW/DW defaults, state encoding (ST_INIT, ST_RUN), and request struct/concatenation layout {wr, add, din} of width 1+AW+DW.
- One sub-module: sync_fifo (parameterised width/depth, push/pop/full/empty/count). Instantiated twice: request FIFO width 1+AW+DW, response FIFO width DW.

Test Plan:
- INIT_CLEAR=1: release rst, hold req_valid=0 -> exactly 4096 cycles with wr=1 and add 0..4095 ascending with din=0, then req_ready=1 and busy=0.
- Write 0xA5 to 0x123, then read 0x123, rsp_ready=1 -> pins show wr at 0x123 then rd at 0x123 on consecutive cycles; rsp_data=0xA5 one cycle after dout valid (RD_LAT=1).
- 8 back-to-back reads of 0x000..0x007 (pre-written 0x10..0x17) with rsp_ready=0 -> only 4 reads issue and req_ready drops. rsp_ready=1 -> responses 0x10..0x17 in order with no loss or duplicates.
- rsp_ready toggled every other cycle during a 16-read burst -> rsp_data stable while stalled; all 16 values returned in order.
- Assert rst low with 3 requests queued and 1 read in flight -> next cycle cen=rd=wr=0 and rsp_valid=0; after release, INIT repeats and no stale response appears.
- Alternating write/read to the same address 0xFFF with incrementing data 0x00..0x0F -> each read returns the immediately preceding write's value.
